// File: rtl/store_pack_pkg.sv
// store_pack_pkg: op encodings, lane masks and entry layout shared by the store packer.
package store_pack_pkg;
    localparam logic [1:0] ST_W = 2'd0;
    localparam logic [1:0] ST_H = 2'd1;
    localparam logic [1:0] ST_B = 2'd2;
    localparam logic [1:0] ST_R = 2'd3;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;
endpackage

// File: rtl/store_fifo.sv
// store_fifo: DEPTH-entry synchronous FIFO with occupancy; output reads zero when empty.
module store_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 68
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    output logic                   full,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic do_push, do_pop;
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = empty ? '0 : mem[rd];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;
endmodule

// File: rtl/store_pack.sv
// store_pack: packs sw/sh/sb into word address, lane data and byte enables, buffered in a FIFO.
// STORE_PACK_ALIGN_EXC_EN rejects misaligned sh/sw instead of clearing the low offset bits.
module store_pack
    import store_pack_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [AW-1:0]          req_addr,
    input  logic [31:0]            req_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic                   err,
    output logic [$clog2(DEPTH):0] count
);
    logic [1:0] off, eoff;
    logic bad, acc, full, empty;
    logic [3:0] be;
    logic [31:0] wdata;
    assign off = req_addr[1:0];
`ifdef STORE_PACK_ALIGN_EXC_EN
    assign bad = req_op == ST_R || (req_op == ST_H && off[0]) || (req_op == ST_W && off != 2'b00);
    assign eoff = off;
`else
    assign bad = req_op == ST_R;
    assign eoff = req_op == ST_W ? 2'b00 : req_op == ST_H ? {off[1], 1'b0} : off;
`endif
    assign be = req_op == ST_B ? BE_BYTE << eoff : req_op == ST_H ? BE_HALF << eoff : BE_WORD;
    assign wdata = req_op == ST_W ? req_data : req_op == ST_H ? {2{req_data[15:0]}} : {4{req_data[7:0]}};
    assign acc = req_valid && req_ready;
    assign req_ready = !full;
    assign mem_valid = !empty;
    store_fifo #(.DEPTH(DEPTH), .W(AW + 36)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(acc && !bad),
        .din({req_addr[AW-1:2], 2'b00, wdata, be}),
        .full(full),
        .pop(mem_ready),
        .dout({mem_addr, mem_wdata, mem_be}),
        .empty(empty),
        .count(count)
    );
    // Rejected requests still complete the handshake; only the error pulse reports them.
    always_ff @(posedge clk or posedge reset)
        if (reset) err <= 1'b0;
        else err <= acc && bad;
endmodule

// File: tb/tb_store_pack.sv
// tb_store_pack: table-driven and sequence checks of store_pack with an entry scoreboard.
module tb_store_pack;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          enq;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          err;
    } vec_t;

    logic clk = 0, reset;
    logic req_valid, req_ready, mem_valid, mem_ready, err;
    logic [1:0] req_op, count;
    logic [31:0] req_addr, req_data, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    int checks = 0, errors = 0;
    exp_t q[$];
    vec_t tbl[11];

    store_pack dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1;
        req_op = op;
        req_addr = addr;
        req_data = data;
    endtask

    always @(negedge clk)
        if (!reset && mem_valid && mem_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got entry addr %h expected none", mem_addr);
            end else begin : cmp
                exp_t e;
                e = q.pop_front();
                chk("pop_addr", mem_addr, e.addr);
                chk("pop_wdata", mem_wdata, e.wdata);
                chk("pop_be", {28'd0, mem_be}, {28'd0, e.be});
            end
        end

    initial begin
        reset = 1; req_valid = 0; req_op = 0; req_addr = 0; req_data = 0; mem_ready = 0;
        tbl[0] = '{2'd2, 32'h1003, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5, 0};
        tbl[1] = '{2'd2, 32'h1000, 32'h1234567F, 1, 4'b0001, 32'h7F7F7F7F, 0};
        tbl[2] = '{2'd2, 32'h1001, 32'h00000042, 1, 4'b0010, 32'h42424242, 0};
        tbl[3] = '{2'd1, 32'h2000, 32'h1234BEEF, 1, 4'b0011, 32'hBEEFBEEF, 0};
        tbl[4] = '{2'd1, 32'h2002, 32'hAAAA5555, 1, 4'b1100, 32'h55555555, 0};
        tbl[5] = '{2'd0, 32'h2004, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, 0};
        tbl[6] = '{2'd3, 32'h4000, 32'h11111111, 0, 4'b0000, 32'h0, 1};
`ifdef STORE_PACK_ALIGN_EXC_EN
        tbl[7] = '{2'd1, 32'h3001, 32'h00001234, 0, 4'b0000, 32'h0, 1};
        tbl[8] = '{2'd0, 32'h3006, 32'hDEADBEEF, 0, 4'b0000, 32'h0, 1};
        tbl[9] = '{2'd1, 32'h3003, 32'h0000ABCD, 0, 4'b0000, 32'h0, 1};
`else
        tbl[7] = '{2'd1, 32'h3001, 32'h00001234, 1, 4'b0011, 32'h12341234, 0};
        tbl[8] = '{2'd0, 32'h3006, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 0};
        tbl[9] = '{2'd1, 32'h3003, 32'h0000ABCD, 1, 4'b1100, 32'hABCDABCD, 0};
`endif
        tbl[10] = '{2'd3, 32'h5002, 32'h22222222, 0, 4'b0000, 32'h0, 1};
        #12 reset = 0;
        @(negedge clk);
        chk("rst_count", {30'd0, count}, 0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 0);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", {28'd0, mem_be}, 0);
        @(posedge clk); #1 mem_ready = 1;
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            chk("tbl_req_ready", {31'd0, req_ready}, 1);
            drive(tbl[i].op, tbl[i].addr, tbl[i].data);
            if (tbl[i].enq) q.push_back('{{tbl[i].addr[31:2], 2'b00}, tbl[i].wdata, tbl[i].be});
            @(posedge clk); #1 req_valid = 0;
            @(negedge clk);
            chk("tbl_err", {31'd0, err}, {31'd0, tbl[i].err});
            @(negedge clk);
            chk("tbl_err_pulse", {31'd0, err}, 0);
            chk("tbl_count", {30'd0, count}, 0);
        end
        @(posedge clk); #1 mem_ready = 0;
        drive(2'd1, 32'h2002, 32'h1234BEEF);
        q.push_back('{32'h2000, 32'hBEEFBEEF, 4'b1100});
        @(posedge clk); #1 drive(2'd0, 32'h2004, 32'hCAFEF00D);
        q.push_back('{32'h2004, 32'hCAFEF00D, 4'b1111});
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("full_count", {30'd0, count}, 2);
        chk("full_req_ready", {31'd0, req_ready}, 0);
        chk("full_head_be", {28'd0, mem_be}, 32'hC);
        chk("full_head_wdata", mem_wdata, 32'hBEEFBEEF);
        @(posedge clk); #1 drive(2'd2, 32'h6000, 32'h00000011);
        mem_ready = 1;
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("full_pop_count", {30'd0, count}, 1);
        chk("full_pop_err", {31'd0, err}, 0);
        chk("second_be", {28'd0, mem_be}, 32'hF);
        @(negedge clk);
        chk("drain_valid", {31'd0, mem_valid}, 0);
        chk("drain_count", {30'd0, count}, 0);
        @(posedge clk); #1 mem_ready = 0;
        drive(2'd2, 32'h7001, 32'h0000005A);
        q.push_back('{32'h7000, 32'h5A5A5A5A, 4'b0010});
        @(posedge clk); #1 drive(2'd0, 32'h7004, 32'h01020304);
        q.push_back('{32'h7004, 32'h01020304, 4'b1111});
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("pre_rst_count", {30'd0, count}, 2);
        #2 reset = 1;
        #1;
        chk("async_rst_count", {30'd0, count}, 0);
        chk("async_rst_valid", {31'd0, mem_valid}, 0);
        chk("async_rst_ready", {31'd0, req_ready}, 1);
        q.delete();
        @(posedge clk);
        @(posedge clk); #2 reset = 0;
        mem_ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_valid", {31'd0, mem_valid}, 0);
        end
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_pack.md
Name: store_pack

Overview:
- Store-side counterpart to the immediate/load extenders.
- Narrows a 32-bit register value (rt) into the byte lanes of a word-addressed data memory for sw/sh/sb: produces a word address, lane-shifted write data and byte enables.
- Buffers accepted stores in a small FIFO with valid/ready handshakes on both sides.
- Sits between the MEM-stage store issue and the DM write port.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept the request this cycle.
- req_op  in  2  0=sw, 1=sh, 2=sb, 3=reserved.
- req_addr  in  AW  byte address.
- req_data  in  32  rt value; low byte/half used for sb/sh.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  DM accepts head entry.
- mem_addr  out  AW  word-aligned address ({req_addr[AW-1:2],2'b00}).
- mem_wdata  out  32  lane-placed data.
- mem_be  out  4  byte enables; bit i = byte lane i (bits 8i+7:8i).
- err  out  1  one-cycle pulse: request rejected.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: rd/wr pointers 0, count=0, mem_valid=0, err=0. mem_addr/mem_wdata/mem_be read 0 when empty. Reset mid-operation discards all buffered entries; no partial write is issued after reset deasserts.
- Handshakes:
  - Push when req_valid && req_ready. Pop when mem_valid && mem_ready.
  - req_ready = (count != DEPTH). No pass-through on full: when full, push is refused even if a pop occurs in the same cycle.
- Packing, at push time, with off = req_addr[1:0]:
  - sw: be=4'b1111, wdata=req_data.
  - sh: be=4'b0011 << off (off ∈ {0,2}); wdata={2{req_data[15:0]}}.
  - sb: be=4'b0001 << off; wdata={4{req_data[7:0]}}.
  - Lanes outside be are don't-care but driven with the replicated value, as above.
- Illegal requests: reserved op (3), or misalignment (sh with off[0]=1; sw with off!=0).
  - Accepted by the handshake (req_ready obeyed).
  - Not enqueued; count unchanged.
  - err=1 in the following cycle.
  - Misalignment detection is subject to ALIGN_EXC_EN (see Optional Feature). Reserved op always errors.
- Latency: an entry pushed at edge N is visible on mem_* after edge N (registered storage, no combinational req→mem path). Head is held stable while mem_valid && !mem_ready.
- Occupancy:
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Push into empty with pop false: count=1.
  - Pointers wrap modulo DEPTH.
- FIFO order is strict; no merging of stores to the same word.

Optional Feature:
- Macro: STORE_PACK_ALIGN_EXC_EN.
- Defined: misaligned sh/sw are rejected as above (err pulse, not enqueued).
- Undefined: misalignment is ignored. The offending low address bits are forced to 0 (sh uses off&2'b10; sw uses off=0) and the store is enqueued normally. err fires only for reserved op.

Decomposition:
- Shared package holds:
  - op encodings: ST_W=0, ST_H=1, ST_B=2.
  - lane mask constants: BE_WORD=4'b1111, BE_HALF=4'b0011, BE_BYTE=4'b0001.
  - a packed entry struct {addr, wdata, be}.
- One natural sub-module: store_fifo, a generic DEPTH-entry sync FIFO with count. It holds the packed entries.
- store_pack owns packing/validation and instantiates store_fifo.

Test Plan:
- Reset, then sb addr=0x1003 data=0x000000A5 → next cycle mem_valid=1, mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5.
- sh addr=0x2002 data=0x1234BEEF, then sw addr=0x2004 data=0xCAFEF00D, mem_ready=0 → count=2, req_ready=0, head be=4'b1100 wdata=0xBEEFBEEF. Raise mem_ready → second entry be=4'b1111 wdata=0xCAFEF00D, then mem_valid=0.
- Full (count=2) with req_valid=1 and mem_ready=1 in the same cycle → pop occurs, push refused, count=1.
- With STORE_PACK_ALIGN_EXC_EN: sh addr=0x3001 → err pulses 1 cycle, count stays 0. Without the macro: same stimulus → enqueued with mem_be=4'b0011, mem_addr=0x3000.
- req_op=3 → err pulse, nothing enqueued, in both builds.
- Assert reset asynchronously mid-cycle with count=2 → count=0, mem_valid=0 immediately. After release, no stale entry appears.
